// File: rtl/count_decoder3.sv
// Decoder for a mod-8 counter that steps by +3/-3: tracks direction, net position
// and a saturating count of illegal transitions, with resynchronisation after an error.
module count_decoder3 #(
    parameter int POS_W = 8,
    parameter int ERR_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid,
    input  logic [2:0]              count,
    input  logic                    clr,
    output logic                    step,
    output logic                    dir,
    output logic                    hold,
    output logic                    err,
    output logic                    locked,
    output logic signed [POS_W-1:0] position,
    output logic [ERR_W-1:0]        err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t                  state, state_next;
    logic [2:0]              prev, prev_next, diff;
    logic signed [POS_W-1:0] pos_next;
    logic [ERR_W-1:0]        err_cnt_next;
    logic                    dir_next, step_next, hold_next, err_next;

    // Mod-8 wraparound of the 3-bit subtraction gives the forward distance directly.
    always_comb begin
        diff         = count - prev;
        state_next   = state;
        prev_next    = prev;
        pos_next     = position;
        err_cnt_next = err_cnt;
        dir_next     = dir;
        step_next    = 1'b0;
        hold_next    = 1'b0;
        err_next     = 1'b0;

        if (clr) begin
            state_next   = IDLE;
            pos_next     = '0;
            err_cnt_next = '0;
            dir_next     = 1'b0;
        end else if (valid) begin
            case (state)
                IDLE: begin
                    prev_next  = count;
                    state_next = TRACK;
                end
                TRACK: begin
                    case (diff)
                        3'd3: begin
                            step_next = 1'b1;
                            dir_next  = 1'b1;
                            pos_next  = position + POS_W'(1);
                            prev_next = count;
                        end
                        3'd5: begin
                            step_next = 1'b1;
                            dir_next  = 1'b0;
                            pos_next  = position - POS_W'(1);
                            prev_next = count;
                        end
                        3'd0: begin
                            hold_next = 1'b1;
                        end
                        default: begin
                            // The pulse still fires once the counter has saturated.
                            err_next   = 1'b1;
                            prev_next  = count;
                            state_next = RESYNC;
                            if (err_cnt != ERR_MAX) begin
                                err_cnt_next = err_cnt + ERR_W'(1);
                            end
                        end
                    endcase
                end
                RESYNC: begin
                    prev_next  = count;
                    state_next = TRACK;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            prev     <= '0;
            position <= '0;
            err_cnt  <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
            hold     <= 1'b0;
            err      <= 1'b0;
            locked   <= 1'b0;
        end else begin
            state    <= state_next;
            prev     <= prev_next;
            position <= pos_next;
            err_cnt  <= err_cnt_next;
            dir      <= dir_next;
            step     <= step_next;
            hold     <= hold_next;
            err      <= err_next;
            locked   <= (state_next == TRACK);
        end
    end

endmodule

// File: tb/tb_count_decoder3.sv
// Self-checking bench for count_decoder3: two instances (POS_W=8 and POS_W=4) share
// stimulus and are compared each cycle against a mode/position/error-count model.
module tb_count_decoder3;

    logic       clk = 1'b0;
    logic       reset, valid, clr;
    logic [2:0] count;

    logic       step, dir, hold, err, locked;
    logic [7:0] position;
    logic [3:0] err_cnt;
    logic       step4, dir4, hold4, err4, locked4;
    logic [3:0] position4;
    logic [3:0] err_cnt4;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 = idle, 1 = tracking, 2 = resynchronising.
    int m_mode = 0;
    int m_prev = 0;
    int m_pos  = 0;
    int m_errs = 0;
    bit m_dir = 0, m_step = 0, m_hold = 0, m_err = 0;

    count_decoder3 #(.POS_W(8), .ERR_W(4)) dut (
        .clk(clk), .reset(reset), .valid(valid), .count(count), .clr(clr),
        .step(step), .dir(dir), .hold(hold), .err(err), .locked(locked),
        .position(position), .err_cnt(err_cnt)
    );

    count_decoder3 #(.POS_W(4), .ERR_W(4)) dut4 (
        .clk(clk), .reset(reset), .valid(valid), .count(count), .clr(clr),
        .step(step4), .dir(dir4), .hold(hold4), .err(err4), .locked(locked4),
        .position(position4), .err_cnt(err_cnt4)
    );

    always #5 clk = ~clk;

    logic [29:0] obs;
    assign obs = {step, dir, hold, err, locked, position, err_cnt,
                  step4, dir4, hold4, err4, locked4, position4, err_cnt4};

    function automatic logic [29:0] exp_vec();
        logic [31:0] p;
        logic [31:0] e;
        logic        lk;
        p  = m_pos;
        e  = m_errs;
        lk = (m_mode == 1);
        return {m_step, m_dir, m_hold, m_err, lk, p[7:0], e[3:0],
                m_step, m_dir, m_hold, m_err, lk, p[3:0], e[3:0]};
    endfunction

    task automatic model_update();
        int d;
        m_step = 0;
        m_hold = 0;
        m_err  = 0;
        if (!reset) begin
            m_mode = 0; m_prev = 0; m_pos = 0; m_errs = 0; m_dir = 0;
        end else if (clr) begin
            m_mode = 0; m_pos = 0; m_errs = 0; m_dir = 0;
        end else if (valid) begin
            d = (int'(count) - m_prev + 8) % 8;
            if (m_mode == 0 || m_mode == 2) begin
                m_prev = count;
                m_mode = 1;
            end else if (d == 3) begin
                m_step = 1; m_dir = 1; m_pos = m_pos + 1; m_prev = count;
            end else if (d == 5) begin
                m_step = 1; m_dir = 0; m_pos = m_pos - 1; m_prev = count;
            end else if (d == 0) begin
                m_hold = 1;
            end else begin
                m_err = 1; m_prev = count; m_mode = 2;
                if (m_errs < 15) m_errs = m_errs + 1;
            end
        end
    endtask

    task automatic tick(input logic r, input logic c, input logic v, input logic [2:0] cnt);
        reset = r;
        clr   = c;
        valid = v;
        count = cnt;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 3'd0);
        tick(1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b1, 3'($urandom_range(0, 7)));
            tests++;
            if (obs !== 30'd0) begin
                fails++;
                $display("[TB] FAIL reset_%0d: got %h expected %h", i, obs, 30'd0);
            end
        end
    endtask

    task automatic test_up();
        int ups;
        int seq [5] = '{0, 3, 6, 1, 4};
        do_reset();
        ups = 0;
        foreach (seq[i]) begin
            tick(1'b1, 1'b0, 1'b1, 3'(seq[i]));
            if (step) ups++;
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL up_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        tests++;
        if (ups != 4 || position !== 8'd4 || dir !== 1'b1 || err_cnt !== 4'd0 || locked !== 1'b1) begin
            fails++;
            $display("[TB] FAIL up_final: got steps=%0d pos=%h dir=%b errs=%0d expected 4 04 1 0",
                     ups, position, dir, err_cnt);
        end
    endtask

    task automatic test_down();
        int seq [4] = '{0, 5, 2, 7};
        do_reset();
        foreach (seq[i]) begin
            tick(1'b1, 1'b0, 1'b1, 3'(seq[i]));
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL down_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        tests++;
        if (position !== 8'hFD || dir !== 1'b0) begin
            fails++;
            $display("[TB] FAIL down_final: got pos=%h dir=%b expected fd 0", position, dir);
        end
    endtask

    task automatic test_hold_err();
        int seq [5] = '{3, 3, 4, 1, 6};
        do_reset();
        foreach (seq[i]) begin
            tick(1'b1, 1'b0, 1'b1, 3'(seq[i]));
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL hold_err_%0d: got %h expected %h", i, obs, exp_vec());
            end
            if (i == 2) begin
                tests++;
                if (err !== 1'b1 || locked !== 1'b0 || err_cnt !== 4'd1) begin
                    fails++;
                    $display("[TB] FAIL resync_entry: got err=%b locked=%b errs=%0d expected 1 0 1",
                             err, locked, err_cnt);
                end
            end
        end
        tests++;
        if (position !== 8'hFF || dir !== 1'b0) begin
            fails++;
            $display("[TB] FAIL hold_err_final: got pos=%h dir=%b expected ff 0", position, dir);
        end
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        tick(1'b1, 1'b0, 1'b1, 3'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 1'b1, 3'((m_prev + 3) % 8));
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL wrap_%0d: got %h expected %h", i, obs, exp_vec());
            end
            if (i == 6) begin
                tests++;
                if (position4 !== 4'h7) begin
                    fails++;
                    $display("[TB] FAIL wrap_max: got %h expected 7", position4);
                end
            end
        end
        tests++;
        if (position4 !== 4'h8) begin
            fails++;
            $display("[TB] FAIL wrap_min: got %h expected 8", position4);
        end
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b0, 1'b1, 3'((m_prev + 1) % 8));
            tests++;
            if (obs !== exp_vec() || err4 !== 1'b1) begin
                fails++;
                $display("[TB] FAIL sat_err_%0d: got %h expected %h", i, obs, exp_vec());
            end
            tick(1'b1, 1'b0, 1'b1, 3'($urandom_range(0, 7)));
        end
        tests++;
        if (err_cnt4 !== 4'd15 || err_cnt !== 4'd15) begin
            fails++;
            $display("[TB] FAIL sat_final: got %0d/%0d expected 15", err_cnt4, err_cnt);
        end
    endtask

    task automatic test_gap();
        do_reset();
        tick(1'b1, 1'b0, 1'b1, 3'd0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
            tests++;
            if (step !== 1'b0 || hold !== 1'b0 || err !== 1'b0 || obs !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL gap_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        tick(1'b1, 1'b0, 1'b1, 3'd3);
        tests++;
        if (step !== 1'b1 || position !== 8'd1) begin
            fails++;
            $display("[TB] FAIL gap_step: got step=%b pos=%h expected 1 01", step, position);
        end
    endtask

    task automatic test_clr();
        do_reset();
        tick(1'b1, 1'b0, 1'b1, 3'd1);
        tick(1'b1, 1'b0, 1'b1, 3'd4);
        tick(1'b1, 1'b0, 1'b1, 3'd7);
        tick(1'b1, 1'b1, 1'b1, 3'd2);
        tests++;
        if (obs !== exp_vec() || position !== 8'd0 || locked !== 1'b0 || step !== 1'b0) begin
            fails++;
            $display("[TB] FAIL clr_valid: got %h expected %h", obs, exp_vec());
        end
        tick(1'b1, 1'b0, 1'b1, 3'd2);
        tick(1'b1, 1'b0, 1'b1, 3'd5);
        tick(1'b1, 1'b0, 1'b1, 3'd6);
        tick(1'b0, 1'b1, 1'b1, 3'd1);
        tests++;
        if (obs !== 30'd0) begin
            fails++;
            $display("[TB] FAIL reset_over_clr: got %h expected %h", obs, 30'd0);
        end
        tick(1'b1, 1'b0, 1'b1, 3'd5);
        tests++;
        if (obs !== exp_vec() || step !== 1'b0 || locked !== 1'b1) begin
            fails++;
            $display("[TB] FAIL first_after_reset: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [2:0] c;
        int         sel;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      c = 3'((m_prev + 3) % 8);
            else if (sel < 6) c = 3'((m_prev + 5) % 8);
            else if (sel < 8) c = 3'(m_prev);
            else              c = 3'($urandom_range(0, 7));
            tick(($urandom_range(0, 59) != 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) != 0), c);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
            end
            tests++;
            if ($countones({step, hold, err}) > 1) begin
                fails++;
                $display("[TB] FAIL pulse_onehot_%0d: got %b%b%b expected at most one", i, step, hold, err);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        clr   = 1'b0;
        valid = 1'b0;
        count = 3'd0;
        test_reset();
        test_up();
        test_down();
        test_hold_err();
        test_wrap_saturate();
        test_gap();
        test_clr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
